// File: rtl/latch_sampler_pkg.sv
// latch_sampler_pkg: shared FSM state encoding for the gated-latch reader
package latch_sampler_pkg;
   typedef enum logic [1:0] {
      WAIT_OPEN = 2'd0,
      OPEN      = 2'd1,
      CAPTURE   = 2'd2
   } state_t;
endpackage

// File: rtl/latch_sampler_sync_fifo.sv
// sync_fifo: registered-head FIFO; out_data holds the last head once drained
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_data;
   logic [AW-1:0]    r_wr, r_rd, w_rd_n;
   logic [AW:0]      r_count, w_cnt_n;
   logic             w_push, w_pop;
   logic [WIDTH-1:0] w_head;
   assign empty   = r_count == '0;
   assign full    = r_count == (AW+1)'(DEPTH);
   assign w_pop   = pop & ~empty;
   assign w_push  = push & (~full | w_pop);
   assign w_rd_n  = r_rd + AW'(w_pop);
   assign w_cnt_n = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
   // the word landing at the new head slot this cycle is not in r_mem yet
   assign w_head  = (w_push && r_wr == w_rd_n) ? din : r_mem[w_rd_n];
   assign dout    = r_data;
   assign count   = r_count;
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_data  <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_mem[r_wr] <= din;
         r_wr    <= r_wr + AW'(w_push);
         r_rd    <= w_rd_n;
         r_count <= w_cnt_n;
         r_data  <= (w_cnt_n != '0) ? w_head : r_data;
      end
   end
endmodule

// File: rtl/latch_sampler.sv
// latch_sampler: synchronises a latch gate and captures its data once per gate close
module latch_sampler
   import latch_sampler_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     lat_g,
   input  logic [WIDTH-1:0]         lat_q,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_gd, r_ovf;
   state_t                 r_state, w_next;
   logic                   w_gs, w_rise, w_fall, w_push, w_pop, w_full, w_empty;
   assign w_gs   = r_sync[SYNC_STAGES-1];
   assign w_rise = w_gs & ~r_gd;
   assign w_fall = ~w_gs & r_gd;
   assign w_push = r_state == CAPTURE;
   assign w_pop  = ~w_empty & out_ready;
   assign out_valid = ~w_empty;
   assign overflow  = r_ovf;
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_sync  <= '0;
         r_gd    <= 1'b0;
         r_state <= WAIT_OPEN;
         r_ovf   <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], lat_g};
         r_gd    <= w_gs;
         r_state <= w_next;
         r_ovf   <= r_ovf | (w_push & w_full & ~w_pop);
      end
   end
   // CAPTURE and the unused encoding both fall through to WAIT_OPEN
   always_comb begin
      w_next = WAIT_OPEN;
      case (r_state)
         WAIT_OPEN: w_next = w_rise ? OPEN : WAIT_OPEN;
         OPEN:      w_next = w_fall ? CAPTURE : OPEN;
         default:   w_next = WAIT_OPEN;
      endcase
   end
   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (w_push),
      .pop   (w_pop),
      .din   (lat_q),
      .dout  (out_data),
      .full  (w_full),
      .empty (w_empty),
      .count (count)
   );
endmodule

// File: tb/tb_latch_sampler.sv
// tb_latch_sampler: directed checks of capture latency, fill/overflow, wrap and reset
module tb_latch_sampler;
   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       lat_g = 1'b0;
   logic [7:0] lat_q = 8'h00;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] count;
   logic       overflow;
   int         n_vec = 0;
   int         n_err = 0;

   latch_sampler #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .clr       (clr),
      .lat_g     (lat_g),
      .lat_q     (lat_q),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // gate high 4 cycles, drop it with data d, then wait n_low edges
   task automatic pulse(input logic [7:0] d, input int n_low);
      lat_g = 1'b1;
      tick(4);
      lat_q = d;
      lat_g = 1'b0;
      tick(n_low);
   endtask

   task automatic drain_one(input string tag, input logic [7:0] exp);
      check(tag, {31'd0, out_valid}, 32'd1);
      check(tag, {24'd0, out_data}, {24'd0, exp});
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         lat_g = ~lat_g;
         tick(1);
      end
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_data", {24'd0, out_data}, 32'd0);
      lat_g = 1'b0;
      clr = 1'b1;
      tick(6);
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);

      lat_g = 1'b1;
      tick(4);
      lat_q = 8'hA5;
      lat_g = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         check("lat_early", {31'd0, out_valid}, 32'd0);
      end
      tick(1);
      check("lat_valid", {31'd0, out_valid}, 32'd1);
      check("lat_data", {24'd0, out_data}, 32'hA5);
      check("lat_count", {29'd0, count}, 32'd1);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check("pop_valid", {31'd0, out_valid}, 32'd0);
      check("pop_count", {29'd0, count}, 32'd0);
      check("hold_data", {24'd0, out_data}, 32'hA5);
      tick(3);

      for (int i = 1; i <= 5; i++) pulse(8'(i), 4);
      check("fill_count", {29'd0, count}, 32'd4);
      check("fill_ovf", {31'd0, overflow}, 32'd1);
      for (int i = 1; i <= 4; i++) drain_one("fill_drain", 8'(i));
      check("fill_empty", {31'd0, out_valid}, 32'd0);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);

      clr = 1'b0;
      tick(1);
      clr = 1'b1;
      check("clr_ovf", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 4; i++) pulse(8'h21 + 8'(i), 4);
      check("sim_full", {29'd0, count}, 32'd4);
      pulse(8'h25, 3);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      tick(2);
      check("sim_count", {29'd0, count}, 32'd4);
      check("sim_ovf", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 4; i++) drain_one("sim_drain", 8'h22 + 8'(i));

      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pulse(8'h10 + 8'(i), 4);
         check("wrap_valid", {31'd0, out_valid}, 32'd1);
         check("wrap_data", {24'd0, out_data}, {24'd0, 8'h10 + 8'(i)});
         tick(4);
      end
      out_ready = 1'b0;
      check("wrap_count", {29'd0, count}, 32'd0);
      check("wrap_ovf", {31'd0, overflow}, 32'd0);

      pulse(8'h77, 3);
      clr = 1'b0;
      #1;
      check("mid_rst_count", {29'd0, count}, 32'd0);
      tick(1);
      clr = 1'b1;
      tick(6);
      check("mid_valid", {31'd0, out_valid}, 32'd0);
      check("mid_count", {29'd0, count}, 32'd0);
      check("mid_data", {24'd0, out_data}, 32'd0);

      clr = 1'b0;
      lat_g = 1'b1;
      tick(1);
      clr = 1'b1;
      tick(4);
      lat_q = 8'h3C;
      lat_g = 1'b0;
      tick(4);
      check("hi_rel_valid", {31'd0, out_valid}, 32'd1);
      check("hi_rel_data", {24'd0, out_data}, 32'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
